per2axi_resp_channel: RTL and testbench

Response stage of the peripheral-to-AXI bridge, directly downstream of the request channel. Consumes AXI4 read-data (R) and write-response (B) beats, arbitrates between them, and returns one registered 32-bit response per cycle to the peripheral interconnect slave port. It captures the request channel's transaction sideband (`trans_req/id/add`) so each read can pick the correct 32-bit half of the 64-bit AXI beat.

---
 rtl/per2axi_resp_channel.sv | 246 ++++++++++++++++++++++++
 tb/tb_per2axi_resp_channel.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/per2axi_resp_channel.sv
// -----------------------------------------------------------------------------
// per2axi_resp_channel
//
// Response stage of the peripheral-to-AXI bridge. It takes AXI4 R and B beats,
// grants one of them per cycle (alternating on ties), and returns a registered
// 32-bit response to the peripheral interconnect. A select table, written from
// the request channel's sideband, remembers for each AXI ID which 32-bit half
// of the 64-bit R beat the peripheral asked for.
//
// Optional feature (compile-time macro PER2AXI_RESP_CHECK_EN):
//   Tracks one pending-read bit per AXI ID. R beats for non-pending IDs are
//   accepted but dropped, and err_o is set sticky. A new read to an ID that is
//   already pending also sets err_o. Without the macro err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   trans_req_i/id_i/add_i  read accepted by the request channel (bit 2 used)
//   axi_master_r_*          AXI R channel (ready is an output)
//   axi_master_b_*          AXI B channel (ready is an output)
//   per_slave_r_*           registered peripheral response
//   err_o                   sticky protocol-error flag
// -----------------------------------------------------------------------------
module per2axi_resp_channel #(
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,

    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,

    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,

    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,
    output logic                      err_o
);

    localparam int NUM_IDS = 2 ** AXI_ID_WIDTH;

    // last_gnt encoding: 1 = R was granted last, 0 = B was granted last
    localparam logic GNT_B = 1'b0;
    localparam logic GNT_R = 1'b1;

    // One-hot peripheral ID from an AXI ID; out-of-range IDs map to all zeros.
    function automatic logic [PER_ID_WIDTH-1:0] onehot_id(input logic [AXI_ID_WIDTH-1:0] axi_id);
        logic [PER_ID_WIDTH-1:0] res;
        logic [31:0]             idx;
        res = {PER_ID_WIDTH{1'b0}};
        idx = {{(32-AXI_ID_WIDTH){1'b0}}, axi_id};
        for (int i = 0; i < PER_ID_WIDTH; i++) begin
            if (idx == 32'(i)) begin
                res[i] = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

    logic [NUM_IDS-1:0]      sel_r;
    logic                    last_gnt_r;
    logic                    r_gnt_s;
    logic                    b_gnt_s;
    logic                    resp_en_s;
    logic                    resp_opc_s;
    logic [PER_ID_WIDTH-1:0] resp_id_s;
    logic [31:0]             resp_rdata_s;

    logic                    resp_valid_r;
    logic                    resp_opc_r;
    logic [PER_ID_WIDTH-1:0] resp_id_r;
    logic [31:0]             resp_rdata_r;

    // Inputs that carry no information for this stage (single-beat bursts,
    // ignored user bits, address bits other than 2, low resp bits).
    logic unused_s;
    assign unused_s = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                        axi_master_r_resp_i[0], axi_master_b_resp_i[0],
                        trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0]};

    // Arbitration: a lone valid wins; on a tie the channel not granted last wins.
    always_comb begin
        r_gnt_s = 1'b0;
        b_gnt_s = 1'b0;
        if (rst_i) begin
            r_gnt_s = 1'b0;
            b_gnt_s = 1'b0;
        end else begin
            case ({axi_master_r_valid_i, axi_master_b_valid_i})
                2'b10:   r_gnt_s = 1'b1;
                2'b01:   b_gnt_s = 1'b1;
                2'b11: begin
                    if (last_gnt_r == GNT_B) begin
                        r_gnt_s = 1'b1;
                    end else begin
                        b_gnt_s = 1'b1;
                    end
                end
                default: begin
                    r_gnt_s = 1'b0;
                    b_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign axi_master_r_ready_o = r_gnt_s;
    assign axi_master_b_ready_o = b_gnt_s;

`ifdef PER2AXI_RESP_CHECK_EN
    logic [NUM_IDS-1:0] pending_r;
    logic               err_r;

    // Pending-read bookkeeping; a new request wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r <= {NUM_IDS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (trans_req_i && (trans_id_i == AXI_ID_WIDTH'(i))) begin
                    pending_r[i] <= 1'b1;
                end else if (r_gnt_s && (axi_master_r_id_i == AXI_ID_WIDTH'(i))) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Sticky protocol error: unexpected R beat or request to a pending ID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if ((r_gnt_s && !pending_r[axi_master_r_id_i]) ||
                     (trans_req_i && pending_r[trans_id_i])) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;

    // Unexpected R beats are consumed without producing a response.
    always_comb begin
        resp_en_s = 1'b0;
        if (r_gnt_s) begin
            resp_en_s = pending_r[axi_master_r_id_i];
        end else begin
            resp_en_s = b_gnt_s;
        end
    end
`else
    assign err_o     = 1'b0;
    assign resp_en_s = r_gnt_s | b_gnt_s;
`endif

    // Response contents for the granted channel; sel_r is read before this
    // cycle's table write lands, giving read-before-write on an ID collision.
    always_comb begin
        resp_opc_s   = 1'b0;
        resp_id_s    = {PER_ID_WIDTH{1'b0}};
        resp_rdata_s = 32'h0000_0000;
        if (r_gnt_s) begin
            resp_opc_s = axi_master_r_resp_i[1];
            resp_id_s  = onehot_id(axi_master_r_id_i);
            if (sel_r[axi_master_r_id_i]) begin
                resp_rdata_s = axi_master_r_data_i[63:32];
            end else begin
                resp_rdata_s = axi_master_r_data_i[31:0];
            end
        end else begin
            resp_opc_s   = axi_master_b_resp_i[1];
            resp_id_s    = onehot_id(axi_master_b_id_i);
            resp_rdata_s = 32'h0000_0000;
        end
    end

    // Half-word select table written from the request channel sideband.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_r <= {NUM_IDS{1'b0}};
        end else if (trans_req_i) begin
            sel_r[trans_id_i] <= trans_add_i[2];
        end else begin
            sel_r <= sel_r;
        end
    end

    // Remember which channel won the last grant for tie breaking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_r <= GNT_B;
        end else if (r_gnt_s) begin
            last_gnt_r <= GNT_R;
        end else if (b_gnt_s) begin
            last_gnt_r <= GNT_B;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    // Registered response: valid pulses for one cycle, payload holds when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_r <= 1'b0;
            resp_opc_r   <= 1'b0;
            resp_id_r    <= {PER_ID_WIDTH{1'b0}};
            resp_rdata_r <= 32'h0000_0000;
        end else if (resp_en_s) begin
            resp_valid_r <= 1'b1;
            resp_opc_r   <= resp_opc_s;
            resp_id_r    <= resp_id_s;
            resp_rdata_r <= resp_rdata_s;
        end else begin
            resp_valid_r <= 1'b0;
        end
    end

    assign per_slave_r_valid_o = resp_valid_r;
    assign per_slave_r_opc_o   = resp_opc_r;
    assign per_slave_r_id_o    = resp_id_r;
    assign per_slave_r_rdata_o = resp_rdata_r;

endmodule

// File: tb/tb_per2axi_resp_channel.sv
// -----------------------------------------------------------------------------
// tb_per2axi_resp_channel
//
// Directed testbench for per2axi_resp_channel. Inputs change 1 time unit after
// a rising edge; registered outputs are checked at the same point, readies are
// checked 1 time unit after the inputs are applied.
// -----------------------------------------------------------------------------
module tb_per2axi_resp_channel;

    logic        clk;
    logic        rst;
    logic        trans_req;
    logic [2:0]  trans_id;
    logic [31:0] trans_add;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        r_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        b_ready;
    logic        p_valid;
    logic        p_opc;
    logic [4:0]  p_id;
    logic [31:0] p_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    per2axi_resp_channel dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .trans_req_i          (trans_req),
        .trans_id_i           (trans_id),
        .trans_add_i          (trans_add),
        .axi_master_r_valid_i (r_valid),
        .axi_master_r_data_i  (r_data),
        .axi_master_r_resp_i  (r_resp),
        .axi_master_r_last_i  (r_last),
        .axi_master_r_id_i    (r_id),
        .axi_master_r_user_i  (r_user),
        .axi_master_r_ready_o (r_ready),
        .axi_master_b_valid_i (b_valid),
        .axi_master_b_resp_i  (b_resp),
        .axi_master_b_id_i    (b_id),
        .axi_master_b_user_i  (b_user),
        .axi_master_b_ready_o (b_ready),
        .per_slave_r_valid_o  (p_valid),
        .per_slave_r_opc_o    (p_opc),
        .per_slave_r_id_o     (p_id),
        .per_slave_r_rdata_o  (p_rdata),
        .err_o                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic o,
                            input logic [4:0] id, input logic [31:0] d);
        chk({tag, "_valid"}, {31'd0, p_valid}, {31'd0, v});
        chk({tag, "_opc"},   {31'd0, p_opc},   {31'd0, o});
        chk({tag, "_id"},    {27'd0, p_id},    {27'd0, id});
        chk({tag, "_rdata"}, p_rdata, d);
    endtask

    task automatic chk_ready(input string tag, input logic rr, input logic br);
        #1;
        chk({tag, "_rready"}, {31'd0, r_ready}, {31'd0, rr});
        chk({tag, "_bready"}, {31'd0, b_ready}, {31'd0, br});
    endtask

    initial begin
        rst = 1'b1; trans_req = 1'b0; trans_id = 3'd0; trans_add = 32'h0000_0000;
        r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b1; r_id = 3'd0; r_user = 6'd0;
        b_valid = 1'b0; b_resp = 2'b00; b_id = 3'd0; b_user = 6'd0;

        // Reset state
        r_valid = 1'b1; b_valid = 1'b1;
        chk_ready("rst_hold", 1'b0, 1'b0);
        r_valid = 1'b0; b_valid = 1'b0;
        cycle(); cycle();
        chk_resp("reset", 1'b0, 1'b0, 5'b00000, 32'h0000_0000);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Read, upper half
        trans_req = 1'b1; trans_id = 3'd2; trans_add = 32'h1000_0004;
        cycle();
        trans_req = 1'b0;
        r_valid = 1'b1; r_id = 3'd2; r_data = 64'hAAAA_BBBB_CCCC_DDDD; r_resp = 2'b00;
        chk_ready("rd_up", 1'b1, 1'b0);
        cycle();
        chk_resp("rd_up", 1'b1, 1'b0, 5'b00100, 32'hAAAA_BBBB);
        r_valid = 1'b0;
        cycle();
        chk_resp("idle_hold", 1'b0, 1'b0, 5'b00100, 32'hAAAA_BBBB);

        // Write error
        b_valid = 1'b1; b_id = 3'd0; b_resp = 2'b10;
        chk_ready("wr_err", 1'b0, 1'b1);
        cycle();
        chk_resp("wr_err", 1'b1, 1'b1, 5'b00001, 32'h0000_0000);
        b_valid = 1'b0;

        // Tie arbitration: last grant was B, so R wins first
        trans_req = 1'b1; trans_id = 3'd1; trans_add = 32'h0000_0000;
        cycle();
        trans_req = 1'b0;
        r_valid = 1'b1; r_id = 3'd1; r_data = 64'h1111_2222_3333_4444; r_resp = 2'b00;
        b_valid = 1'b1; b_id = 3'd3; b_resp = 2'b00;
        chk_ready("tie1", 1'b1, 1'b0);
        cycle();
        chk_resp("tie1", 1'b1, 1'b0, 5'b00010, 32'h3333_4444);
        chk_ready("tie2", 1'b0, 1'b1);
        cycle();
        chk_resp("tie2", 1'b1, 1'b0, 5'b01000, 32'h0000_0000);
        r_valid = 1'b0; b_valid = 1'b0;
        cycle();
        chk_resp("tie_idle", 1'b0, 1'b0, 5'b01000, 32'h0000_0000);

        // Same-cycle table hazard on id 4
        trans_req = 1'b1; trans_id = 3'd4; trans_add = 32'h0000_0004;
        cycle();
        trans_add = 32'h0000_0000;
        r_valid = 1'b1; r_id = 3'd4; r_data = 64'h5555_6666_7777_8888; r_resp = 2'b00;
        cycle();
        chk_resp("haz_old", 1'b1, 1'b0, 5'b10000, 32'h5555_6666);
        trans_req = 1'b0;
        cycle();
        chk_resp("haz_new", 1'b1, 1'b0, 5'b10000, 32'h7777_8888);
        r_valid = 1'b0;

        // Out-of-range ID on B (EXOKAY): id 0, response still issued
        b_valid = 1'b1; b_id = 3'd6; b_resp = 2'b01;
        cycle();
        chk_resp("b_oor", 1'b1, 1'b0, 5'b00000, 32'h0000_0000);
        b_valid = 1'b0;
`ifndef PER2AXI_RESP_CHECK_EN
        chk("err_tied", {31'd0, err}, 32'd0);
`endif

        // Reset mid-flight: sel[3]=1, reset in the handshake cycle
        trans_req = 1'b1; trans_id = 3'd3; trans_add = 32'h0000_0004;
        cycle();
        trans_req = 1'b0;
        rst = 1'b1;
        r_valid = 1'b1; r_id = 3'd3; r_data = 64'h9999_AAAA_BBBB_CCCC; r_resp = 2'b10;
        chk_ready("rst_mid", 1'b0, 1'b0);
        cycle();
        chk_resp("rst_mid", 1'b0, 1'b0, 5'b00000, 32'h0000_0000);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        cycle();
`ifdef PER2AXI_RESP_CHECK_EN
        chk_resp("post_rst", 1'b0, 1'b0, 5'b00000, 32'h0000_0000);
        chk("post_rst_err", {31'd0, err}, 32'd1);
`else
        chk_resp("post_rst", 1'b1, 1'b1, 5'b01000, 32'hBBBB_CCCC);
`endif
        r_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Unexpected R beat on id 6
        r_valid = 1'b1; r_id = 3'd6; r_data = 64'h0123_4567_89AB_CDEF; r_resp = 2'b00;
        chk_ready("unexp", 1'b1, 1'b0);
        cycle();
        r_valid = 1'b0;
`ifdef PER2AXI_RESP_CHECK_EN
        chk_resp("unexp", 1'b0, 1'b0, 5'b00000, 32'h0000_0000);
        chk("unexp_err", {31'd0, err}, 32'd1);
        cycle(); cycle();
        chk("err_sticky", {31'd0, err}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("err_clr", {31'd0, err}, 32'd0);
`else
        chk_resp("unexp", 1'b1, 1'b0, 5'b00000, 32'h89AB_CDEF);
        chk("unexp_err", {31'd0, err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
